mem_wb_stage: RTL and testbench

- Consumer end of the EX-stage output interface. Takes alu_result/store_data/rd/writeback controls from the EX stage and registers them (EX/MEM boundary).
- Performs the load/store handshake to data memory, stalling EX while an access is outstanding.
- Produces registered single-cycle writeback strobes to the integer and FP register files.

---
 rtl/mem_wb_stage_if.sv | 39 +++
 rtl/mem_wb_stage.sv | 159 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// Signal bundle between the EX stage / data memory / register files and the MEM-WB stage.
// The slave view belongs to mem_wb_stage; the master view is the surrounding pipeline and memory.
interface mem_wb_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd_out;
  logic        wb_sel_out;
  logic        wb_fp_en_out;
  logic        wb_int_en_out;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_int_we;
  logic        wb_fp_we;
  logic        mem_err;

  modport slave (
    input  ex_valid, alu_result, store_data, rd_out, wb_sel_out, wb_fp_en_out,
           wb_int_en_out, ex_mem_read, ex_mem_write, dmem_ack, dmem_rdata,
    output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_rd, wb_data, wb_int_we, wb_fp_we, mem_err
  );

  modport master (
    output ex_valid, alu_result, store_data, rd_out, wb_sel_out, wb_fp_en_out,
           wb_int_en_out, ex_mem_read, ex_mem_write, dmem_ack, dmem_rdata,
    input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_rd, wb_data, wb_int_we, wb_fp_we, mem_err
  );
endinterface

// File: rtl/mem_wb_stage.sv
// EX/MEM boundary register, data-memory handshake with timeout, and registered
// single-cycle writeback strobes to the integer and FP register files.
module mem_wb_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_wb_stage_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

  state_t      state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic        dmem_req_r, dmem_req_s;
  logic        dmem_we_r, dmem_we_s;
  logic [31:0] dmem_addr_r, dmem_addr_s;
  logic [31:0] dmem_wdata_r, dmem_wdata_s;
  logic [4:0]  wb_rd_r, wb_rd_s;
  logic [31:0] wb_data_r, wb_data_s;
  logic        wb_int_we_r, wb_int_we_s;
  logic        wb_fp_we_r, wb_fp_we_s;
  logic        mem_err_r, mem_err_s;
  logic [4:0]  lat_rd_r, lat_rd_s;
  logic        lat_sel_r, lat_sel_s;
  logic        lat_int_en_r, lat_int_en_s;
  logic        lat_fp_en_r, lat_fp_en_s;
  logic        illegal_s;

  assign bus.ex_ready   = (state_r == ST_IDLE);
  assign bus.dmem_req   = dmem_req_r;
  assign bus.dmem_we    = dmem_we_r;
  assign bus.dmem_addr  = dmem_addr_r;
  assign bus.dmem_wdata = dmem_wdata_r;
  assign bus.wb_rd      = wb_rd_r;
  assign bus.wb_data    = wb_data_r;
  assign bus.wb_int_we  = wb_int_we_r;
  assign bus.wb_fp_we   = wb_fp_we_r;
  assign bus.mem_err    = mem_err_r;

  // Both mem flags at once, or a word access off a 4-byte boundary, is rejected.
  assign illegal_s = (bus.ex_mem_read & bus.ex_mem_write) | (bus.alu_result[1:0] != 2'b00);

  // Next-state and next-output computation for the access FSM.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    dmem_req_s   = dmem_req_r;
    dmem_we_s    = dmem_we_r;
    dmem_addr_s  = dmem_addr_r;
    dmem_wdata_s = dmem_wdata_r;
    wb_rd_s      = wb_rd_r;
    wb_data_s    = wb_data_r;
    wb_int_we_s  = 1'b0;
    wb_fp_we_s   = 1'b0;
    mem_err_s    = 1'b0;
    lat_rd_s     = lat_rd_r;
    lat_sel_s    = lat_sel_r;
    lat_int_en_s = lat_int_en_r;
    lat_fp_en_s  = lat_fp_en_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.ex_valid) begin
          if (!bus.ex_mem_read && !bus.ex_mem_write) begin
            wb_data_s   = bus.alu_result;
            wb_rd_s     = bus.rd_out;
            wb_int_we_s = bus.wb_int_en_out & (bus.rd_out != 5'd0);
            wb_fp_we_s  = bus.wb_fp_en_out;
          end else if (illegal_s) begin
            mem_err_s = 1'b1;
          end else begin
            state_s      = ST_WAIT_ACK;
            cnt_s        = {CNT_W{1'b0}};
            dmem_req_s   = 1'b1;
            dmem_we_s    = bus.ex_mem_write;
            dmem_addr_s  = bus.alu_result;
            dmem_wdata_s = bus.store_data;
            lat_rd_s     = bus.rd_out;
            lat_sel_s    = bus.wb_sel_out;
            lat_int_en_s = bus.wb_int_en_out;
            lat_fp_en_s  = bus.wb_fp_en_out;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        if (bus.dmem_ack) begin
          state_s    = ST_IDLE;
          dmem_req_s = 1'b0;
          dmem_we_s  = 1'b0;
          // dmem_addr_r still carries the latched alu_result for a load with wb_sel=0.
          if (!dmem_we_r) begin
            wb_rd_s     = lat_rd_r;
            wb_data_s   = lat_sel_r ? bus.dmem_rdata : dmem_addr_r;
            wb_int_we_s = lat_int_en_r & (lat_rd_r != 5'd0);
            wb_fp_we_s  = lat_fp_en_r;
          end else begin
            wb_rd_s = wb_rd_r;
          end
        end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
          state_s    = ST_IDLE;
          dmem_req_s = 1'b0;
          dmem_we_s  = 1'b0;
          mem_err_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s    = ST_IDLE;
        dmem_req_s = 1'b0;
        dmem_we_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      dmem_req_r   <= 1'b0;
      dmem_we_r    <= 1'b0;
      dmem_addr_r  <= 32'd0;
      dmem_wdata_r <= 32'd0;
      wb_rd_r      <= 5'd0;
      wb_data_r    <= 32'd0;
      wb_int_we_r  <= 1'b0;
      wb_fp_we_r   <= 1'b0;
      mem_err_r    <= 1'b0;
      lat_rd_r     <= 5'd0;
      lat_sel_r    <= 1'b0;
      lat_int_en_r <= 1'b0;
      lat_fp_en_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      dmem_req_r   <= dmem_req_s;
      dmem_we_r    <= dmem_we_s;
      dmem_addr_r  <= dmem_addr_s;
      dmem_wdata_r <= dmem_wdata_s;
      wb_rd_r      <= wb_rd_s;
      wb_data_r    <= wb_data_s;
      wb_int_we_r  <= wb_int_we_s;
      wb_fp_we_r   <= wb_fp_we_s;
      mem_err_r    <= mem_err_s;
      lat_rd_r     <= lat_rd_s;
      lat_sel_r    <= lat_sel_s;
      lat_int_en_r <= lat_int_en_s;
      lat_fp_en_r  <= lat_fp_en_s;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized bench for mem_wb_stage against a transaction-level model.
module tb_mem_wb_stage;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic check_en = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: one outstanding access at most, abandoned after TIMEOUT unacked request cycles.
  logic        m_busy = 1'b0;
  int          m_waited = 0;
  logic        m_load = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic        m_sel = 1'b0, m_int = 1'b0, m_fp = 1'b0;
  logic        e_req = 1'b0, e_we = 1'b0;
  logic [31:0] e_addr = 32'd0, e_wdata = 32'd0;
  logic [4:0]  e_wb_rd = 5'd0;
  logic [31:0] e_wb_data = 32'd0;
  logic        e_int = 1'b0, e_fp = 1'b0, e_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_waited <= 0;
      e_req <= 1'b0; e_we <= 1'b0; e_addr <= 32'd0; e_wdata <= 32'd0;
      e_wb_rd <= 5'd0; e_wb_data <= 32'd0; e_int <= 1'b0; e_fp <= 1'b0; e_err <= 1'b0;
    end else begin
      e_int <= 1'b0; e_fp <= 1'b0; e_err <= 1'b0;
      if (!m_busy) begin
        if (bus.ex_valid) begin
          if (!bus.ex_mem_read && !bus.ex_mem_write) begin
            e_wb_data <= bus.alu_result;
            e_wb_rd   <= bus.rd_out;
            e_int     <= bus.wb_int_en_out && (bus.rd_out != 5'd0);
            e_fp      <= bus.wb_fp_en_out;
          end else if ((bus.ex_mem_read && bus.ex_mem_write) || (bus.alu_result % 32'd4 != 32'd0)) begin
            e_err <= 1'b1;
          end else begin
            m_busy <= 1'b1; m_waited <= 0;
            m_load <= bus.ex_mem_read; m_rd <= bus.rd_out; m_sel <= bus.wb_sel_out;
            m_int <= bus.wb_int_en_out; m_fp <= bus.wb_fp_en_out;
            e_req <= 1'b1; e_we <= bus.ex_mem_write;
            e_addr <= bus.alu_result; e_wdata <= bus.store_data;
          end
        end
      end else if (bus.dmem_ack) begin
        m_busy <= 1'b0; e_req <= 1'b0; e_we <= 1'b0;
        if (m_load) begin
          e_wb_rd   <= m_rd;
          e_wb_data <= m_sel ? bus.dmem_rdata : e_addr;
          e_int     <= m_int && (m_rd != 5'd0);
          e_fp      <= m_fp;
        end
      end else if (m_waited + 1 == TIMEOUT) begin
        m_busy <= 1'b0; e_req <= 1'b0; e_we <= 1'b0; e_err <= 1'b1;
      end else begin
        m_waited <= m_waited + 1;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("ex_ready", bus.ex_ready, !m_busy);
      chk("dmem_req", bus.dmem_req, e_req);
      chk("dmem_we", bus.dmem_we, e_we);
      chk("dmem_addr", bus.dmem_addr, e_addr);
      chk("dmem_wdata", bus.dmem_wdata, e_wdata);
      chk("wb_rd", bus.wb_rd, e_wb_rd);
      chk("wb_data", bus.wb_data, e_wb_data);
      chk("wb_int_we", bus.wb_int_we, e_int);
      chk("wb_fp_we", bus.wb_fp_we, e_fp);
      chk("mem_err", bus.mem_err, e_err);
    end
  end

  task automatic drive(input logic v, input logic mr, input logic mw, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [4:0] rd, input logic sel,
                       input logic fpen, input logic inten);
    bus.ex_valid = v; bus.ex_mem_read = mr; bus.ex_mem_write = mw;
    bus.alu_result = alu; bus.store_data = sd; bus.rd_out = rd;
    bus.wb_sel_out = sel; bus.wb_fp_en_out = fpen; bus.wb_int_en_out = inten;
  endtask

  initial begin
    int cnt;
    int ack_pct;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;
    @(negedge clk);
    chk("reset ex_ready", bus.ex_ready, 32'd1);
    chk("reset wb_data", bus.wb_data, 32'd0);
    chk("reset dmem_req", bus.dmem_req, 32'd0);

    // ALU op to the FP file
    drive(1'b1, 1'b0, 1'b0, 32'h3F800000, 32'd0, 5'd5, 1'b0, 1'b1, 1'b0);
    @(negedge clk); bus.ex_valid = 1'b0;
    chk("alu fp_we", bus.wb_fp_we, 32'd1);
    chk("alu wb_rd", bus.wb_rd, 32'd5);
    chk("alu wb_data", bus.wb_data, 32'h3F800000);
    chk("alu int_we", bus.wb_int_we, 32'd0);

    // Load acked three cycles after the request rises
    drive(1'b1, 1'b1, 1'b0, 32'h100, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0);
    @(negedge clk); bus.ex_valid = 1'b0;
    chk("load ex_ready busy", bus.ex_ready, 32'd0);
    chk("load req", bus.dmem_req, 32'd1);
    chk("load addr", bus.dmem_addr, 32'h100);
    @(negedge clk);
    @(negedge clk); bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h40490FDB;
    @(negedge clk); bus.dmem_ack = 1'b0;
    chk("load fp_we", bus.wb_fp_we, 32'd1);
    chk("load wb_data", bus.wb_data, 32'h40490FDB);
    chk("load wb_rd", bus.wb_rd, 32'd3);
    chk("load ex_ready", bus.ex_ready, 32'd1);

    // Store acked on the first request cycle
    drive(1'b1, 1'b0, 1'b1, 32'h204, 32'hDEADBEEF, 5'd7, 1'b0, 1'b0, 1'b1);
    @(negedge clk); bus.ex_valid = 1'b0;
    chk("store we", bus.dmem_we, 32'd1);
    chk("store wdata", bus.dmem_wdata, 32'hDEADBEEF);
    bus.dmem_ack = 1'b1;
    @(negedge clk); bus.dmem_ack = 1'b0;
    chk("store req done", bus.dmem_req, 32'd0);
    chk("store we done", bus.dmem_we, 32'd0);
    chk("store no int_we", bus.wb_int_we, 32'd0);

    // Misaligned load
    drive(1'b1, 1'b1, 1'b0, 32'h102, 32'd0, 5'd4, 1'b1, 1'b0, 1'b1);
    @(negedge clk); bus.ex_valid = 1'b0;
    chk("misalign err", bus.mem_err, 32'd1);
    chk("misalign req", bus.dmem_req, 32'd0);
    @(negedge clk);
    chk("misalign err pulse", bus.mem_err, 32'd0);

    // Integer write to x0
    drive(1'b1, 1'b0, 1'b0, 32'h55, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); bus.ex_valid = 1'b0;
    chk("x0 int_we", bus.wb_int_we, 32'd0);
    chk("x0 wb_data", bus.wb_data, 32'h55);

    // Load never acked
    drive(1'b1, 1'b1, 1'b0, 32'h300, 32'd0, 5'd9, 1'b1, 1'b0, 1'b1);
    @(negedge clk); bus.ex_valid = 1'b0;
    cnt = 0;
    while (bus.dmem_req && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("timeout req cycles", cnt, 32'd16);
    chk("timeout err", bus.mem_err, 32'd1);
    chk("timeout ex_ready", bus.ex_ready, 32'd1);
    chk("timeout int_we", bus.wb_int_we, 32'd0);
    bus.dmem_ack = 1'b1;
    @(negedge clk); bus.dmem_ack = 1'b0;
    chk("late ack int_we", bus.wb_int_we, 32'd0);
    chk("late ack err", bus.mem_err, 32'd0);

    // Reset during an outstanding load
    drive(1'b1, 1'b1, 1'b0, 32'h400, 32'd0, 5'd2, 1'b1, 1'b1, 1'b1);
    @(negedge clk); bus.ex_valid = 1'b0;
    chk("rst pre req", bus.dmem_req, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst req drop", bus.dmem_req, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    bus.dmem_ack = 1'b1;
    @(negedge clk); bus.dmem_ack = 1'b0;
    chk("rst ex_ready", bus.ex_ready, 32'd1);
    chk("rst no wb", bus.wb_int_we | bus.wb_fp_we, 32'd0);

    // Randomized traffic
    ack_pct = 30;
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [31:0] alu;
      if (i % 150 == 0) begin
        r = $urandom_range(2);
        ack_pct = (r == 0) ? 0 : ((r == 1) ? 25 : 80);
      end
      r = $urandom_range(7);
      alu = $urandom;
      if ($urandom_range(3) != 0) alu[1:0] = 2'b00;
      drive($urandom_range(1) == 1, (r == 4) || (r == 5) || (r == 7), (r == 6) || (r == 7),
            alu, $urandom, 5'($urandom_range(31)), $urandom_range(1) == 1,
            $urandom_range(1) == 1, $urandom_range(1) == 1);
      bus.dmem_ack = ($urandom_range(99) < ack_pct);
      bus.dmem_rdata = $urandom;
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
